fsk_frame_rx: RTL and testbench
===============================

// Module: fsk_frame_rx
// PURPOSE
//  Line-side FSK receiver. It demodulates a 1-bit FSK square wave (comparator output) by measuring
//  the edge-to-edge interval, recovers bit timing from the start bit, deframes nibbles and checks
//  them. It is the far end of the encode -> FSK transmit path: it consumes what the FSK modulator
//  drives onto the line and hands verified nibbles to the host.
// PARAMETERS
//  CLKS_PER_BIT  64  clk cycles per transmitted bit (must be even, >= 4*SPACE_HALF)
//  MARK_HALF     4   nominal half-period, in clks, of the '1' (mark) tone
//  SPACE_HALF    8   nominal half-period, in clks, of the '0' (space) tone
//  CARRIER_TO    32  edge interval (clks) at or beyond which the carrier is declared lost
//  DATA_W        4   data bits per frame
// PORTS
//  clk         in   1       system clock; all logic is on the rising edge
//  rst         in   1       synchronous, active-high reset
//  fsk_in      in   1       asynchronous FSK line input
//  data_out    out  DATA_W  last correctly received word; held until the next good frame
//  valid       out  1       1-cycle pulse; data_out has just been updated
//  parity_err  out  1       1-cycle pulse; frame dropped on an even-parity mismatch
//  frame_err   out  1       1-cycle pulse; bad stop bit, or carrier lost mid-frame
//  carrier_ok  out  1       level; a carrier is currently being detected
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, synchroniser flops 1, demod bit 1 (mark).
//  Input: 2-FF synchroniser, then an edge detector (either polarity). Edge pulse = sync'd cycle + 1.
//  Interval counter: cleared on each edge, +1 otherwise, saturates at CARRIER_TO.
//    On an edge with prior count < THR = (MARK_HALF+SPACE_HALF)/2 (integer div): demod=1.
//    Otherwise demod=0.
//    When count reaches CARRIER_TO: carrier_ok<=0, demod<=1. First edge afterwards: carrier_ok<=1.
//  Frame: idle=mark; start=0; DATA_W bits LSB first; even parity bit (total ones incl. parity
//    even); stop=1.
//  FSM: IDLE, START, DATA, PARITY, STOP, BREAK. bit_cnt counts clks; idx counts data bits.
//   IDLE:   demod falls 1->0 -> START, bit_cnt=0.
//   START:  at bit_cnt=CLKS_PER_BIT/2-1, sample demod. 0 -> DATA, 1 -> IDLE (glitch, no pulse).
//   DATA:   sample every CLKS_PER_BIT clks into shift reg[idx]. After DATA_W samples -> PARITY.
//   PARITY: one sample, stored. -> STOP.
//   STOP:   one sample. stop=1 and parity ok -> data_out<=word, valid=1, IDLE.
//     stop=1 and parity bad -> parity_err=1, data_out unchanged, IDLE.
//     stop=0 -> frame_err=1, BREAK (parity not reported).
//   BREAK:  wait for demod=1, then IDLE; no new frame starts from a held space.
//  Pulses are registered and assert the cycle after the stop sample. Pulses are mutually exclusive.
//  Carrier loss in START/DATA/PARITY/STOP -> frame_err pulse next cycle, IDLE, partial word dropped.
//  Carrier loss in IDLE/BREAK -> IDLE, no pulse.
//  rst mid-frame: immediate return to reset state next cycle; no pulse from the aborted frame.
//  Back-to-back frames: a start edge directly after the stop sample is accepted (IDLE already
//    entered).
// TESTING
//  Defaults; tx model: mark=8-clk period, space=16-clk period, 64 clks/bit, >=10 idle bits.
//  1 send 0xA (bits 0,1,0,1, parity 0, stop 1) -> single valid pulse, data_out=4'hA,
//    no err pulses, carrier_ok=1.
//  2 send 0x3 with parity 1 -> parity_err pulse, no valid, data_out keeps 4'hA.
//  3 send 0x5 with stop=0, then hold space 200 clks -> one frame_err; no frame until mark.
//    Then 0xC -> valid with 4'hC.
//  4 space glitch of 20 clks on idle mark -> no pulses, FSM back to IDLE, data_out unchanged.
//  5 hold fsk_in constant 300 clks during data bit 2 -> carrier_ok=0 at 32 clks after last edge;
//    frame_err pulse; next good frame 0x6 -> valid, 4'h6.
//  6 assert rst for 1 cycle during data bit 1 -> all outputs 0; following frame 0x9 -> valid, 4'h9.
//    Also: two frames 0x5, 0xC with zero idle gap -> two valid pulses, in order.

Source files
------------

// File: rtl/fsk_frame_rx_if.sv
// Line-side bundle for the FSK frame receiver: raw line input in, checked nibbles and status out.
interface fsk_frame_rx_if #(
  parameter int DATA_W = 4
);
  logic              fsk_in;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              parity_err;
  logic              frame_err;
  logic              carrier_ok;

  // slave is the receiver itself; master is whatever drives the line and consumes the results
  modport slave  (input fsk_in, output data_out, valid, parity_err, frame_err, carrier_ok);
  modport master (output fsk_in, input data_out, valid, parity_err, frame_err, carrier_ok);
endinterface

// File: rtl/fsk_frame_rx.sv
// FSK receiver: edge-interval demodulator, carrier detect, and start-bit-timed deframer
// with even-parity and stop-bit checking.
module fsk_frame_rx #(
  parameter int CLKS_PER_BIT = 64,
  parameter int MARK_HALF    = 4,
  parameter int SPACE_HALF   = 8,
  parameter int CARRIER_TO   = 32,
  parameter int DATA_W       = 4
) (
  input  logic          clk,
  input  logic          rst,
  fsk_frame_rx_if.slave rxIf
);

  localparam int THR = (MARK_HALF + SPACE_HALF) / 2;
  localparam int CW  = $clog2(CARRIER_TO + 1);
  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int IW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(CARRIER_TO);
  localparam logic [CW-1:0] CNT_THR   = CW'(THR);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} stateT;

  logic          sync1, sync2, sync3;
  logic [CW-1:0] intervalCnt;
  logic          demod;
  logic          carrierOk;
  logic          carrierLost;

  stateT             state;
  logic [BW-1:0]     bitCnt;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] shiftReg;
  logic              parityBit;
  logic              demodPrev;
  logic [DATA_W-1:0] dataOut;
  logic              validReg;
  logic              parityErrReg;
  logic              frameErrReg;

  // Demodulator: short edge spacing means mark, long means space; a silent line reads as mark.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      sync3       <= 1'b1;
      intervalCnt <= '0;
      demod       <= 1'b1;
      carrierOk   <= 1'b0;
      carrierLost <= 1'b0;
    end else begin
      sync1       <= rxIf.fsk_in;
      sync2       <= sync1;
      sync3       <= sync2;
      carrierLost <= 1'b0;
      if (sync2 != sync3) begin
        intervalCnt <= '0;
        demod       <= (intervalCnt < CNT_THR);
        carrierOk   <= 1'b1;
      end else if (intervalCnt != CNT_MAX) begin
        intervalCnt <= intervalCnt + 1'b1;
        if (intervalCnt == CNT_MAX - 1'b1) begin
          carrierOk   <= 1'b0;
          demod       <= 1'b1;
          carrierLost <= 1'b1;
        end
      end
    end
  end

  // Deframer: bit timing is anchored at the start-bit falling edge and sampled mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bitCnt       <= '0;
      idx          <= '0;
      shiftReg     <= '0;
      parityBit    <= 1'b0;
      demodPrev    <= 1'b1;
      dataOut      <= '0;
      validReg     <= 1'b0;
      parityErrReg <= 1'b0;
      frameErrReg  <= 1'b0;
    end else begin
      demodPrev    <= demod;
      validReg     <= 1'b0;
      parityErrReg <= 1'b0;
      frameErrReg  <= 1'b0;
      if (carrierLost) begin
        if (state inside {START, DATA, PARITY, STOP}) frameErrReg <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (demodPrev && !demod) begin
              state  <= START;
              bitCnt <= '0;
            end
          end
          START: begin
            if (bitCnt == HALF_LAST) begin
              bitCnt <= '0;
              idx    <= '0;
              state  <= demod ? IDLE : DATA;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
          DATA: begin
            if (bitCnt == BIT_LAST) begin
              bitCnt        <= '0;
              shiftReg[idx] <= demod;
              if (idx == IDX_LAST) state <= PARITY;
              else                 idx   <= idx + 1'b1;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
          PARITY: begin
            if (bitCnt == BIT_LAST) begin
              bitCnt    <= '0;
              parityBit <= demod;
              state     <= STOP;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
          STOP: begin
            if (bitCnt == BIT_LAST) begin
              bitCnt <= '0;
              if (!demod) begin
                frameErrReg <= 1'b1;
                state       <= BREAK;
              end else if (^{shiftReg, parityBit} == 1'b0) begin
                dataOut  <= shiftReg;
                validReg <= 1'b1;
                state    <= IDLE;
              end else begin
                parityErrReg <= 1'b1;
                state        <= IDLE;
              end
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
          BREAK: begin
            if (demod) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign rxIf.data_out   = dataOut;
  assign rxIf.valid      = validReg;
  assign rxIf.parity_err = parityErrReg;
  assign rxIf.frame_err  = frameErrReg;
  assign rxIf.carrier_ok = carrierOk;

endmodule

// File: tb/tb_fsk_frame_rx.sv
// Directed bench for fsk_frame_rx: a small FSK line model drives frames and faults,
// pulse monitors count receiver outputs, and each step is checked with immediate assertions.
module tb_fsk_frame_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fsk_frame_rx_if #(.DATA_W(4)) rxIf ();

  fsk_frame_rx #(
    .CLKS_PER_BIT(64),
    .MARK_HALF   (4),
    .SPACE_HALF  (8),
    .CARRIER_TO  (32),
    .DATA_W      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rxIf(rxIf)
  );

  int checks = 0;
  int errors = 0;

  int validCnt   = 0;
  int parityCnt  = 0;
  int frameCnt   = 0;
  int overlapCnt = 0;
  logic [3:0] validLog[$];

  always @(negedge clk) begin
    if (rxIf.valid === 1'b1) begin
      validCnt++;
      validLog.push_back(rxIf.data_out);
      $display("valid pulse  data_out=%h  t=%0t", rxIf.data_out, $time);
    end
    if (rxIf.parity_err === 1'b1) begin
      parityCnt++;
      $display("parity_err pulse  t=%0t", $time);
    end
    if (rxIf.frame_err === 1'b1) begin
      frameCnt++;
      $display("frame_err pulse  t=%0t", $time);
    end
    if ((int'(rxIf.valid === 1'b1) + int'(rxIf.parity_err === 1'b1) + int'(rxIf.frame_err === 1'b1)) > 1)
      overlapCnt++;
  end

  logic txLine    = 1'b1;
  int   txHalfCnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txTick(input int half);
    @(negedge clk);
    txHalfCnt++;
    if (txHalfCnt >= half) begin
      txLine    = ~txLine;
      txHalfCnt = 0;
    end
    rxIf.fsk_in = txLine;
  endtask

  task automatic sendBit(input logic b, input int n);
    for (int i = 0; i < n; i++) txTick(b ? 4 : 8);
  endtask

  task automatic holdLine(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [3:0] d, input logic parFlip, input logic stopBit,
                           input int idleBits);
    sendBit(1'b1, idleBits * 64);
    sendBit(1'b0, 64);
    for (int i = 0; i < 4; i++) sendBit(d[i], 64);
    sendBit((^d) ^ parFlip, 64);
    sendBit(stopBit, 64);
    $display("sent frame d=%h parFlip=%0d stop=%0d", d, parFlip, stopBit);
  endtask

  initial begin
    rxIf.fsk_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_valid", rxIf.valid, 1'b0);
    check("reset_parity_err", rxIf.parity_err, 1'b0);
    check("reset_frame_err", rxIf.frame_err, 1'b0);
    check("reset_data_out", rxIf.data_out, 4'h0);
    check("reset_carrier_ok", rxIf.carrier_ok, 1'b0);
    rst = 1'b0;

    // 1: good frame 0xA
    sendFrame(4'hA, 1'b0, 1'b1, 10);
    sendBit(1'b1, 128);
    check("t1_valid_cnt", validCnt, 1);
    check("t1_data_out", rxIf.data_out, 4'hA);
    check("t1_parity_cnt", parityCnt, 0);
    check("t1_frame_cnt", frameCnt, 0);
    check("t1_carrier_ok", rxIf.carrier_ok, 1'b1);

    // 2: 0x3 with the parity bit inverted
    sendFrame(4'h3, 1'b1, 1'b1, 10);
    sendBit(1'b1, 128);
    check("t2_parity_cnt", parityCnt, 1);
    check("t2_valid_cnt", validCnt, 1);
    check("t2_data_out", rxIf.data_out, 4'hA);
    check("t2_frame_cnt", frameCnt, 0);

    // 3: bad stop bit followed by held space, then a good 0xC
    sendFrame(4'h5, 1'b0, 1'b0, 10);
    sendBit(1'b0, 200);
    check("t3_frame_cnt", frameCnt, 1);
    check("t3_valid_cnt_break", validCnt, 1);
    check("t3_parity_cnt", parityCnt, 1);
    sendFrame(4'hC, 1'b0, 1'b1, 10);
    sendBit(1'b1, 128);
    check("t3_valid_cnt", validCnt, 2);
    check("t3_data_out", rxIf.data_out, 4'hC);
    check("t3_frame_cnt_after", frameCnt, 1);

    // 4: short space glitch on an idle line
    sendBit(1'b1, 640);
    sendBit(1'b0, 20);
    sendBit(1'b1, 640);
    check("t4_valid_cnt", validCnt, 2);
    check("t4_parity_cnt", parityCnt, 1);
    check("t4_frame_cnt", frameCnt, 1);
    check("t4_data_out", rxIf.data_out, 4'hC);

    // 5: line freezes during data bit 2 of 0x6
    sendBit(1'b1, 640);
    sendBit(1'b0, 64);
    sendBit(1'b0, 64);
    sendBit(1'b1, 64);
    sendBit(1'b1, 20);
    holdLine(20);
    check("t5_carrier_still_ok", rxIf.carrier_ok, 1'b1);
    holdLine(30);
    check("t5_carrier_lost", rxIf.carrier_ok, 1'b0);
    check("t5_frame_cnt", frameCnt, 2);
    holdLine(250);
    check("t5_frame_cnt_hold", frameCnt, 2);
    check("t5_valid_cnt_hold", validCnt, 2);
    sendFrame(4'h6, 1'b0, 1'b1, 10);
    sendBit(1'b1, 128);
    check("t5_valid_cnt", validCnt, 3);
    check("t5_data_out", rxIf.data_out, 4'h6);
    check("t5_carrier_back", rxIf.carrier_ok, 1'b1);

    // 6: reset during data bit 1, then a good 0x9
    sendBit(1'b1, 640);
    sendBit(1'b0, 64);
    sendBit(1'b1, 64);
    sendBit(1'b0, 30);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_data_out", rxIf.data_out, 4'h0);
    check("t6_rst_valid", rxIf.valid, 1'b0);
    check("t6_rst_carrier_ok", rxIf.carrier_ok, 1'b0);
    check("t6_rst_frame_err", rxIf.frame_err, 1'b0);
    check("t6_rst_parity_err", rxIf.parity_err, 1'b0);
    sendFrame(4'h9, 1'b0, 1'b1, 10);
    sendBit(1'b1, 128);
    check("t6_valid_cnt", validCnt, 4);
    check("t6_data_out", rxIf.data_out, 4'h9);
    check("t6_frame_cnt", frameCnt, 2);
    check("t6_parity_cnt", parityCnt, 1);

    // back-to-back frames with no idle gap
    sendFrame(4'h5, 1'b0, 1'b1, 10);
    sendFrame(4'hC, 1'b0, 1'b1, 0);
    sendBit(1'b1, 128);
    check("b2b_valid_cnt", validCnt, 6);
    check("b2b_log_size", validLog.size(), 6);
    check("b2b_first", (validLog.size() > 4) ? validLog[4] : 4'hx, 4'h5);
    check("b2b_second", (validLog.size() > 5) ? validLog[5] : 4'hx, 4'hC);
    check("b2b_data_out", rxIf.data_out, 4'hC);
    check("b2b_errs", frameCnt + parityCnt, 3);
    check("pulse_overlap", overlapCnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
